fu_issue_fifo_bank: RTL and testbench
=====================================

# fu_issue_fifo_bank

Parametrised successor to the fixed three-wide issue stage. It accepts an `ISSUE_WIDTH`-wide bundle of issued packets from the reservation station and steers each packet by its FU select into one of `NUM_FU` independent per-functional-unit FIFOs of depth `FIFO_DEPTH`. Each FIFO head is presented to its FU with a valid/ready handshake. The block returns per-FU stall back to the reservation station and supports a synchronous squash. It sits between the RS and the FU array.

## Interface
Parameters:
- `ISSUE_WIDTH`, default 3: packets offered per cycle; slot 0 is the oldest.
- `NUM_FU`, default 8: number of FU channels and FIFOs.
- `FIFO_DEPTH`, default 4: entries per FIFO. Must be ≥ `ISSUE_WIDTH` and a power of two.
- `DATA_W`, default 128: packet payload width (opaque to the block).
- `SEL_W`, derived, = $clog2(`NUM_FU`).

Ports:
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `squash`, in, 1: synchronous flush of every FIFO.
- `in_valid`, in, `ISSUE_WIDTH`: per-slot valid.
- `in_fu_sel`, in, `ISSUE_WIDTH`×`SEL_W`: target FU index per slot.
- `in_data`, in, `ISSUE_WIDTH`×`DATA_W`: payload per slot.
- `fu_ready`, in, `NUM_FU`: FU can accept its head this cycle.
- `fu_valid`, out, `NUM_FU`: FIFO f is non-empty.
- `fu_data`, out, `NUM_FU`×`DATA_W`: head entry of FIFO f.
- `fu_stall`, out, `NUM_FU`: free entries in FIFO f < `ISSUE_WIDTH`.
- `fu_count`, out, `NUM_FU`×$clog2(`FIFO_DEPTH`+1): occupancy.
- `overflow`, out, 1: sticky error flag.

## Operation
- Each FIFO holds a storage array, head/tail pointers of width $clog2(`FIFO_DEPTH`), and a count. Pointers wrap modulo `FIFO_DEPTH`.
- Enqueue: every valid slot whose `in_fu_sel`==f writes into FIFO f.
  - Multiple slots targeting the same FU in one cycle are written in ascending slot order at consecutive tail positions.
  - Tail advances by the number written (0..`ISSUE_WIDTH`).
- Dequeue: FIFO f pops its head when `fu_valid[f] && fu_ready[f]`.
- Count update: count_next = count + enq_k − deq. Enqueue and dequeue in the same cycle are both honoured.
- Acceptance limit: a slot is accepted only if count − deq + (its rank among same-FU slots) < `FIFO_DEPTH`.
  - Non-accepted slots are dropped and set `overflow`.
  - The RS honouring `fu_stall` guarantees this never happens in legal operation.
- `fu_stall[f]` = (`FIFO_DEPTH` − count[f]) < `ISSUE_WIDTH`. It is combinational from registered count and does not consider same-cycle dequeue.
- `fu_valid[f]` = count[f] != 0. `fu_data[f]` = storage[head[f]], read combinationally from registered state.
- Squash: all counts and pointers go to 0 and `overflow` is held. Squash has priority over same-cycle enqueue and dequeue, and its enqueues are discarded.
- Reset: all counts and pointers go to 0 and `overflow` goes to 0. Storage is not cleared.
- Reset values of outputs:
  - `fu_valid`=0, `fu_stall`=0, `fu_count`=0, `overflow`=0.
  - `fu_data` = don't-care; the bench must not check it while `fu_valid`=0.

## Timing
- Enqueue latency 1: a packet presented in cycle T is visible at `fu_valid`/`fu_data` in cycle T+1. There is no same-cycle bypass.
- Dequeue: the handshake at edge T removes the head. The next entry or `fu_valid`=0 appears in T+1.
- `fu_stall` reflects occupancy after the previous edge; it is asserted in the cycle after the enqueue that crosses the threshold.
- Full FIFO with `fu_ready`=1 plus one new enqueue: accepted, with count unchanged.
- Reset or squash asserted mid-stream: outputs are empty in the following cycle. Reset has priority over squash.
- Pointer wrap: entries written across the wrap boundary drain in original order.

## Test plan
With `ISSUE_WIDTH`=3, `NUM_FU`=8, `FIFO_DEPTH`=4:
- Slots 0/1/2 → FU 0/3/5 with PCs AAAA_AAAA/BBBB_BBBB/CCCC_CCCC and all `fu_ready`=1 → next cycle `fu_valid`[0,3,5]=1 carrying those PCs; the cycle after, all are 0.
- Three slots → FU 2 (data 1,2,3) with `fu_ready[2]`=0 → `fu_count[2]`=3, `fu_stall[2]`=1, `fu_data[2]`=1. Raise ready → outputs 1,2,3 on consecutive cycles, then `fu_valid[2]`=0 and `fu_stall[2]`=0.
- Fill FU 4 to 4 entries, then hold `fu_ready[4]`=1 while enqueuing one packet per cycle for 6 cycles → count stays 4, output order strictly FIFO across the pointer wrap, `overflow`=0.
- FU 1 holding 2 entries, then squash asserted together with a 3-slot enqueue to FU 1 → next cycle `fu_count[1]`=0 and `fu_valid`=0 on all FUs.
- Ignore stall: 5 packets to FU 6 over two cycles with `fu_ready`=0 → the first 4 are kept in order, the fifth is dropped, `overflow`=1 sticky across a squash, and cleared only by `reset`.
- Assert `reset` with several FIFOs non-empty → next cycle all outputs are at their reset values.

Source files
------------

// File: rtl/fu_issue_fifo_bank_if.sv
// Issue-side and FU-side signal bundle for fu_issue_fifo_bank.
// The bank takes the slave view; the RS/FU side drives through the master view.
interface fu_issue_fifo_bank_if #(
    parameter int ISSUE_WIDTH = 3,
    parameter int NUM_FU      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int DATA_W      = 128,
    parameter int SEL_W       = $clog2(NUM_FU),
    parameter int CNT_W       = $clog2(FIFO_DEPTH + 1)
);
    logic                                  squash;
    logic [ISSUE_WIDTH-1:0]                in_valid;
    logic [ISSUE_WIDTH-1:0][SEL_W-1:0]     in_fu_sel;
    logic [ISSUE_WIDTH-1:0][DATA_W-1:0]    in_data;
    logic [NUM_FU-1:0]                     fu_ready;
    logic [NUM_FU-1:0]                     fu_valid;
    logic [NUM_FU-1:0][DATA_W-1:0]         fu_data;
    logic [NUM_FU-1:0]                     fu_stall;
    logic [NUM_FU-1:0][CNT_W-1:0]          fu_count;
    logic                                  overflow;

    modport master (
        output squash, in_valid, in_fu_sel, in_data, fu_ready,
        input  fu_valid, fu_data, fu_stall, fu_count, overflow
    );

    modport slave (
        input  squash, in_valid, in_fu_sel, in_data, fu_ready,
        output fu_valid, fu_data, fu_stall, fu_count, overflow
    );
endinterface

// File: rtl/fu_issue_fifo_bank.sv
// Steers an ISSUE_WIDTH-wide issue bundle into NUM_FU per-FU FIFOs with
// valid/ready heads, occupancy-based stall, synchronous squash and a sticky overflow flag.

module fu_issue_fifo_lane #(
    parameter int              ISSUE_WIDTH = 3,
    parameter int              FIFO_DEPTH  = 4,
    parameter int              DATA_W      = 128,
    parameter int              SEL_W       = 3,
    parameter logic [SEL_W-1:0] FU_IDX     = '0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               i_squash,
    input  logic [ISSUE_WIDTH-1:0]             i_valid,
    input  logic [ISSUE_WIDTH-1:0][SEL_W-1:0]  i_sel,
    input  logic [ISSUE_WIDTH-1:0][DATA_W-1:0] i_data,
    input  logic                               i_ready,
    output logic                               o_valid,
    output logic [DATA_W-1:0]                  o_data,
    output logic                               o_stall,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count,
    output logic                               o_drop
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // One extra bit keeps count + rank and count + ISSUE_WIDTH from wrapping.
    localparam int SUM_W = CNT_W + 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic                              w_deq;
    logic [SUM_W-1:0]                  w_base;
    logic [SUM_W-1:0]                  w_enq;
    logic [ISSUE_WIDTH-1:0]            w_match;
    logic [ISSUE_WIDTH-1:0]            w_acc;
    logic [ISSUE_WIDTH-1:0][SUM_W-1:0] w_rank;

    assign w_deq  = (r_count != '0) && i_ready;
    assign w_base = SUM_W'(r_count) - SUM_W'(w_deq);

    // Rank counts every earlier same-FU slot; accepted slots form a prefix,
    // so an accepted slot's rank is also its offset from the tail.
    always_comb begin
        logic [SUM_W-1:0] v_rank;
        v_rank  = '0;
        w_enq   = '0;
        w_match = '0;
        w_acc   = '0;
        w_rank  = '0;
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
            w_match[s] = i_valid[s] && (i_sel[s] == FU_IDX);
            w_rank[s]  = v_rank;
            if (w_match[s]) begin
                w_acc[s] = (w_base + v_rank) < SUM_W'(FIFO_DEPTH);
                v_rank   = v_rank + SUM_W'(1);
            end
            if (w_acc[s])
                w_enq = w_enq + SUM_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        for (int s = 0; s < ISSUE_WIDTH; s++)
            if (w_acc[s])
                r_mem[r_tail + PTR_W'(w_rank[s])] <= i_data[s];
    end

    always_ff @(posedge clock) begin
        if (reset || i_squash) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_count <= CNT_W'(w_base + w_enq);
            r_head  <= r_head + PTR_W'(w_deq);
            r_tail  <= r_tail + PTR_W'(w_enq);
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_head];
    assign o_count = r_count;
    assign o_stall = (SUM_W'(r_count) + SUM_W'(ISSUE_WIDTH)) > SUM_W'(FIFO_DEPTH);
    assign o_drop  = |(w_match & ~w_acc) && !i_squash;
endmodule

module fu_issue_fifo_bank #(
    parameter int ISSUE_WIDTH = 3,
    parameter int NUM_FU      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int DATA_W      = 128,
    parameter int SEL_W       = $clog2(NUM_FU)
) (
    input  logic                  clock,
    input  logic                  reset,
    fu_issue_fifo_bank_if.slave   bus
);
    logic [NUM_FU-1:0] w_drop;
    logic              r_overflow;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_lane
        fu_issue_fifo_lane #(
            .ISSUE_WIDTH (ISSUE_WIDTH),
            .FIFO_DEPTH  (FIFO_DEPTH),
            .DATA_W      (DATA_W),
            .SEL_W       (SEL_W),
            .FU_IDX      (SEL_W'(g))
        ) u_lane (
            .clock    (clock),
            .reset    (reset),
            .i_squash (bus.squash),
            .i_valid  (bus.in_valid),
            .i_sel    (bus.in_fu_sel),
            .i_data   (bus.in_data),
            .i_ready  (bus.fu_ready[g]),
            .o_valid  (bus.fu_valid[g]),
            .o_data   (bus.fu_data[g]),
            .o_stall  (bus.fu_stall[g]),
            .o_count  (bus.fu_count[g]),
            .o_drop   (w_drop[g])
        );
    end

    // Sticky until reset; squash leaves it untouched.
    always_ff @(posedge clock) begin
        if (reset)
            r_overflow <= 1'b0;
        else if (|w_drop)
            r_overflow <= 1'b1;
    end

    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_fu_issue_fifo_bank.sv
// Randomized and directed bench for fu_issue_fifo_bank against a queue-based model.
module tb_fu_issue_fifo_bank;
    localparam int IW = 3, NF = 8, D = 4, DW = 128, SW = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fu_issue_fifo_bank_if #(.ISSUE_WIDTH(IW), .NUM_FU(NF), .FIFO_DEPTH(D), .DATA_W(DW)) bus();

    fu_issue_fifo_bank #(.ISSUE_WIDTH(IW), .NUM_FU(NF), .FIFO_DEPTH(D), .DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_tot = 0;
    int          n_bad = 0;
    logic [DW-1:0] mq [NF][$];
    logic        movf = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pops happen before pushes, so a slot fits whenever the post-pop queue has room.
    task automatic model_step();
        int f;
        if (reset) begin
            for (int i = 0; i < NF; i++) mq[i].delete();
            movf = 1'b0;
        end else if (bus.squash) begin
            for (int i = 0; i < NF; i++) mq[i].delete();
        end else begin
            for (int i = 0; i < NF; i++)
                if (mq[i].size() != 0 && bus.fu_ready[i]) void'(mq[i].pop_front());
            for (int s = 0; s < IW; s++)
                if (bus.in_valid[s]) begin
                    f = int'(bus.in_fu_sel[s]);
                    if (mq[f].size() < D) mq[f].push_back(bus.in_data[s]);
                    else movf = 1'b1;
                end
        end
    endtask

    task automatic check_all();
        for (int f = 0; f < NF; f++) begin
            chk($sformatf("valid%0d", f), DW'(bus.fu_valid[f]), DW'(mq[f].size() != 0));
            chk($sformatf("count%0d", f), DW'(bus.fu_count[f]), DW'(mq[f].size()));
            chk($sformatf("stall%0d", f), DW'(bus.fu_stall[f]), DW'((D - mq[f].size()) < IW));
            if (mq[f].size() != 0)
                chk($sformatf("data%0d", f), bus.fu_data[f], mq[f][0]);
        end
        chk("ovf", DW'(bus.overflow), DW'(movf));
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all();
    endtask

    task automatic idle();
        bus.in_valid  = '0;
        bus.in_fu_sel = '0;
        bus.in_data   = '0;
        bus.squash    = 1'b0;
    endtask

    task automatic put(input int s, input int f, input logic [DW-1:0] d);
        bus.in_valid[s]  = 1'b1;
        bus.in_fu_sel[s] = SW'(f);
        bus.in_data[s]   = d;
    endtask

    initial begin
        idle();
        bus.fu_ready = '1;
        step();
        step();
        reset = 1'b0;
        chk("rst_valid", DW'(bus.fu_valid), '0);
        chk("rst_stall", DW'(bus.fu_stall), '0);
        chk("rst_count", DW'(bus.fu_count), '0);
        chk("rst_ovf", DW'(bus.overflow), '0);

        // three slots to three different FUs
        put(0, 0, 'hAAAA_AAAA); put(1, 3, 'hBBBB_BBBB); put(2, 5, 'hCCCC_CCCC);
        step();
        chk("t1_valid", DW'(bus.fu_valid), DW'(8'b0010_1001));
        chk("t1_d0", bus.fu_data[0], 'hAAAA_AAAA);
        chk("t1_d3", bus.fu_data[3], 'hBBBB_BBBB);
        chk("t1_d5", bus.fu_data[5], 'hCCCC_CCCC);
        idle();
        step();
        chk("t1_empty", DW'(bus.fu_valid), '0);

        // three slots to one FU, held then drained
        bus.fu_ready[2] = 1'b0;
        put(0, 2, 1); put(1, 2, 2); put(2, 2, 3);
        step();
        chk("t2_cnt", DW'(bus.fu_count[2]), 3);
        chk("t2_stall", DW'(bus.fu_stall[2]), 1);
        chk("t2_d1", bus.fu_data[2], 1);
        idle();
        bus.fu_ready = '1;
        step();
        chk("t2_d2", bus.fu_data[2], 2);
        step();
        chk("t2_d3", bus.fu_data[2], 3);
        step();
        chk("t2_vld0", DW'(bus.fu_valid[2]), 0);
        chk("t2_stall0", DW'(bus.fu_stall[2]), 0);

        // full FIFO streaming through the pointer wrap
        bus.fu_ready[4] = 1'b0;
        put(0, 4, 'h40); put(1, 4, 'h41); put(2, 4, 'h42);
        step();
        idle();
        put(0, 4, 'h43);
        step();
        chk("t3_full", DW'(bus.fu_count[4]), 4);
        bus.fu_ready[4] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle();
            put(0, 4, DW'('h50 + i));
            step();
            chk("t3_cnt", DW'(bus.fu_count[4]), 4);
            chk("t3_head", bus.fu_data[4], (i < 3) ? DW'('h41 + i) : DW'('h50 + i - 3));
        end
        idle();
        for (int i = 0; i < 4; i++) step();
        chk("t3_ovf", DW'(bus.overflow), 0);

        // squash beats a same-cycle enqueue
        bus.fu_ready[1] = 1'b0;
        put(0, 1, 'h11); put(1, 1, 'h12);
        step();
        idle();
        bus.squash = 1'b1;
        put(0, 1, 'h13); put(1, 1, 'h14); put(2, 1, 'h15);
        step();
        chk("t4_cnt", DW'(bus.fu_count[1]), 0);
        chk("t4_valid", DW'(bus.fu_valid), '0);
        idle();
        bus.fu_ready = '1;

        // ignoring stall: fifth packet dropped, overflow sticky
        bus.fu_ready[6] = 1'b0;
        put(0, 6, 'h60); put(1, 6, 'h61); put(2, 6, 'h62);
        step();
        idle();
        put(0, 6, 'h63); put(1, 6, 'h64);
        step();
        chk("t5_cnt", DW'(bus.fu_count[6]), 4);
        chk("t5_ovf", DW'(bus.overflow), 1);
        chk("t5_head", bus.fu_data[6], 'h60);
        idle();
        bus.fu_ready = '1;
        step();
        step();
        bus.squash = 1'b1;
        step();
        idle();
        chk("t5_ovf_sq", DW'(bus.overflow), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_ovf_rst", DW'(bus.overflow), 0);

        // reset with several FIFOs non-empty
        bus.fu_ready = '0;
        put(0, 0, 'h70); put(1, 7, 'h71); put(2, 7, 'h72);
        step();
        idle();
        put(0, 3, 'h73);
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_valid", DW'(bus.fu_valid), '0);
        chk("t6_count", DW'(bus.fu_count), '0);
        chk("t6_stall", DW'(bus.fu_stall), '0);
        bus.fu_ready = '1;

        // random traffic; stall honoured in the first part only
        for (int c = 0; c < 500; c++) begin
            idle();
            bus.fu_ready = NF'($urandom);
            for (int s = 0; s < IW; s++)
                if ($urandom_range(0, 2) != 0) begin
                    int f;
                    f = int'($urandom_range(0, NF - 1));
                    if (c >= 350 || !bus.fu_stall[f])
                        put(s, f, {$urandom, $urandom, $urandom, $urandom});
                end
            bus.squash = ($urandom_range(0, 39) == 0);
            reset      = ($urandom_range(0, 119) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        step();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
